// File: rtl/operand_fetch_stage.sv
// Operand fetch: 32-entry register file, B-operand select and a one-entry valid/ready output stage.
// Optional macro REGFILE_BYPASS_EN enables same-cycle writeback-to-read forwarding.
module operand_fetch_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [3:0]      alu_ctrl_in,
  input  logic [AW-1:0]   rd_addr_in,
  input  logic            reg_write_in,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A_out,
  output logic [XLEN-1:0] B_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [3:0]      ALUControl_out,
  output logic [AW-1:0]   rd_addr_out,
  output logic            reg_write_out
);

  logic [XLEN-1:0] regs_r [NREG];
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [XLEN-1:0] b_next_s;
  logic            wb_live_s;
  logic            capture_s;

  assign wb_live_s = wb_en && (wb_addr != {AW{1'b0}});
  assign in_ready  = !out_valid || out_ready;
  assign capture_s = in_valid && in_ready && !flush;

  // Register file array update; entry 0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_live_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[wb_addr] <= regs_r[wb_addr];
    end
  end

  // Combinational source reads with x0 hard-wired to zero.
  always_comb begin
    rs1_val_s = {XLEN{1'b0}};
    rs2_val_s = {XLEN{1'b0}};
    if (rs1_addr == {AW{1'b0}}) begin
      rs1_val_s = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wb_live_s && (wb_addr == rs1_addr)) begin
      rs1_val_s = wb_data;
`endif
    end else begin
      rs1_val_s = regs_r[rs1_addr];
    end
    if (rs2_addr == {AW{1'b0}}) begin
      rs2_val_s = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wb_live_s && (wb_addr == rs2_addr)) begin
      rs2_val_s = wb_data;
`endif
    end else begin
      rs2_val_s = regs_r[rs2_addr];
    end
  end

  // B operand: immediate or rs2 value.
  always_comb begin
    b_next_s = {XLEN{1'b0}};
    if (alu_src) begin
      b_next_s = imm;
    end else begin
      b_next_s = rs2_val_s;
    end
  end

  // Output stage: flush beats capture, capture beats drain; reg_write_out follows out_valid low.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      A_out          <= {XLEN{1'b0}};
      B_out          <= {XLEN{1'b0}};
      store_data_out <= {XLEN{1'b0}};
      ALUControl_out <= 4'b0000;
      rd_addr_out    <= {AW{1'b0}};
      reg_write_out  <= 1'b0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      reg_write_out  <= 1'b0;
    end else if (capture_s) begin
      out_valid      <= 1'b1;
      A_out          <= rs1_val_s;
      B_out          <= b_next_s;
      store_data_out <= rs2_val_s;
      ALUControl_out <= alu_ctrl_in;
      rd_addr_out    <= rd_addr_in;
      reg_write_out  <= reg_write_in;
    end else if (out_valid && out_ready) begin
      out_valid      <= 1'b0;
      reg_write_out  <= 1'b0;
    end else begin
      out_valid      <= out_valid;
      reg_write_out  <= reg_write_out;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Table-driven bench for operand_fetch_stage, plus a register-file sweep sequence.
module tb_operand_fetch_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  alu_ctrl_in;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic [31:0] store_data_out;
  logic [3:0]  ALUControl_out;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;

  operand_fetch_stage #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .alu_src(alu_src),
    .alu_ctrl_in(alu_ctrl_in), .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .A_out(A_out), .B_out(B_out),
    .store_data_out(store_data_out), .ALUControl_out(ALUControl_out),
    .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL = 32'hAAAA5555;
`else
  localparam logic [31:0] COLL = 32'h00000001;
`endif

  typedef struct {
    logic rst; logic wen; logic [4:0] wa; logic [31:0] wd;
    logic iv; logic [4:0] r1; logic [4:0] r2; logic [31:0] im; logic src;
    logic [3:0] ctl; logic [4:0] rd; logic rw; logic fl; logic ordy;
    logic rchk; logic xrdy; logic xv; logic dchk;
    logic [31:0] xa; logic [31:0] xb; logic [31:0] xs; logic [3:0] xc; logic [4:0] xrd; logic xrw;
  } vec_t;

  vec_t vq[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [32];

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; in_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; imm = 32'h0;
    alu_src = 1'b0; alu_ctrl_in = 4'h0; rd_addr_in = 5'd0; reg_write_in = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    //        rst  wen  wa     wd             iv   r1     r2     imm            src  ctl    rd      rw   fl   ordy rchk xrdy xv   dchk xa             xb             xs             xc     xrd     xrw
    vq.push_back('{1'b1,1'b1,5'd5, 32'h0000DEAD,1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b1,1'b1,5'd5, 32'h0000DEAD,1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd5, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b1,5'd3, 32'h12345678,1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b1,5'd4, 32'h00000010,1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd3, 5'd4, 32'h0,         1'b0,4'h2, 5'd10, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h12345678,  32'h00000010,  32'h00000010,  4'h2, 5'd10, 1'b1});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd3, 5'd4, 32'hFFFFFFFC,  1'b1,4'h3, 5'd11, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h12345678,  32'hFFFFFFFC,  32'h00000010,  4'h3, 5'd11, 1'b0});
    vq.push_back('{1'b0,1'b1,5'd0, 32'hFFFFFFFF,1'b1,5'd0, 5'd0, 32'h0,         1'b0,4'h1, 5'd1,  1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h0,         32'h0,         32'h0,         4'h1, 5'd1,  1'b1});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 5'd0, 32'h0,         1'b0,4'h5, 5'd2,  1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h0,         32'h0,         32'h0,         4'h5, 5'd2,  1'b1});
    vq.push_back('{1'b0,1'b1,5'd7, 32'h00000001,1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b1,5'd7, 32'hAAAA5555,1'b1,5'd7, 5'd3, 32'h0,         1'b0,4'h6, 5'd7,  1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,COLL,          32'h12345678,  32'h12345678,  4'h6, 5'd7,  1'b1});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd7, 32'h0,         1'b0,4'h7, 5'd8,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'hAAAA5555,  32'hAAAA5555,  32'hAAAA5555,  4'h7, 5'd8,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd4, 5'd3, 32'h00000100,  1'b1,4'h8, 5'd12, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h00000010,  32'h00000100,  32'h12345678,  4'h8, 5'd12, 1'b1});
    for (int k = 0; k < 3; k++)
      vq.push_back('{1'b0,1'b0,5'd0,32'h0,      1'b1,5'd3, 5'd4, 32'h0,         1'b0,4'h9, 5'd13, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h00000010,  32'h00000100,  32'h12345678,  4'h8, 5'd12, 1'b1});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd3, 5'd4, 32'h0,         1'b0,4'h9, 5'd13, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h12345678,  32'h00000010,  32'h00000010,  4'h9, 5'd13, 1'b1});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd0, 32'h0,         1'b0,4'hA, 5'd14, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h12345678,  32'h00000010,  32'h00000010,  4'h9, 5'd13, 1'b1});
    vq.push_back('{1'b0,1'b1,5'd9, 32'h00000099,1'b1,5'd7, 5'd0, 32'h0,         1'b0,4'hA, 5'd14, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd0, 32'h0,         1'b0,4'hA, 5'd14, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd0, 32'h0,         1'b0,4'hB, 5'd15, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00000099,  32'h0,         32'h0,         4'hB, 5'd15, 1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h00000099,  32'h0,         32'h0,         4'hB, 5'd15, 1'b0});
    vq.push_back('{1'b1,1'b1,5'd9, 32'h00000005,1'b1,5'd9, 5'd0, 32'h0,         1'b0,4'hC, 5'd3,  1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});
    vq.push_back('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd0, 32'h0,         1'b0,4'h0, 5'd0,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h0,         32'h0,         32'h0,         4'h0, 5'd0,  1'b0});

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; wb_en = vq[i].wen; wb_addr = vq[i].wa; wb_data = vq[i].wd;
      in_valid = vq[i].iv; rs1_addr = vq[i].r1; rs2_addr = vq[i].r2; imm = vq[i].im;
      alu_src = vq[i].src; alu_ctrl_in = vq[i].ctl; rd_addr_in = vq[i].rd;
      reg_write_in = vq[i].rw; flush = vq[i].fl; out_ready = vq[i].ordy;
      #1;
      if (vq[i].rchk) cmp("in_ready", i, {31'd0, in_ready}, {31'd0, vq[i].xrdy});
      @(posedge clk);
      #1;
      vectors++;
      cmp("out_valid", i, {31'd0, out_valid}, {31'd0, vq[i].xv});
      cmp("reg_write_out", i, {31'd0, reg_write_out}, {31'd0, vq[i].xrw});
      if (vq[i].dchk) begin
        cmp("A_out", i, A_out, vq[i].xa);
        cmp("B_out", i, B_out, vq[i].xb);
        cmp("store_data_out", i, store_data_out, vq[i].xs);
        cmp("ALUControl_out", i, {28'd0, ALUControl_out}, {28'd0, vq[i].xc});
        cmp("rd_addr_out", i, {27'd0, rd_addr_out}, {27'd0, vq[i].xrd});
      end
    end

    // Sweep: fill x1..x31 with distinct values, then read every pair back.
    @(negedge clk);
    idle_inputs();
    model[0] = 32'h0;
    for (int r = 1; r < 32; r++) begin
      model[r] = 32'hC0DE0000 ^ (r * 32'h01010101);
      @(negedge clk);
      wb_en = 1'b1; wb_addr = r[4:0]; wb_data = model[r];
    end
    @(negedge clk);
    wb_en = 1'b0;
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      in_valid = 1'b1; rs1_addr = r[4:0]; rs2_addr = 5'd31 - r[4:0];
      alu_src = 1'b0; alu_ctrl_in = r[3:0]; rd_addr_in = r[4:0]; reg_write_in = r[0];
      @(posedge clk);
      #1;
      vectors++;
      cmp("sweep_valid", 100 + r, {31'd0, out_valid}, 32'd1);
      cmp("sweep_A", 100 + r, A_out, model[r]);
      cmp("sweep_S", 100 + r, store_data_out, model[31 - r]);
      cmp("sweep_B", 100 + r, B_out, model[31 - r]);
      cmp("sweep_rwr", 100 + r, {31'd0, reg_write_out}, {31'd0, r[0]});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    cmp("final_drain", 200, {30'd0, out_valid, reg_write_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Upstream neighbour of the ALU.
- Holds the 32-entry integer register file and reads rs1/rs2.
- Selects the B operand as either the register value or the immediate.
- Registers A, B, the 4-bit ALU control and the writeback tag into a one-entry output stage with a valid/ready handshake. The ALU consumes this stage's outputs directly.

Parameters:
- XLEN, 32, data width of registers and operands
- NREG, 32, number of architectural registers; x0 reads as zero
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction fields valid this cycle
- in_ready  out  1  stage can accept a new instruction
- rs1_addr  in  AW  source register 1
- rs2_addr  in  AW  source register 2
- imm  in  XLEN  sign-extended immediate from decode
- alu_src  in  1  1: B = imm, 0: B = rs2 value
- alu_ctrl_in  in  4  ALU operation code, passed through unchanged
- rd_addr_in  in  AW  destination register tag
- reg_write_in  in  1  instruction writes rd
- wb_en  in  1  writeback write enable
- wb_addr  in  AW  writeback register address
- wb_data  in  XLEN  writeback data
- flush  in  1  discard the held and incoming instruction
- out_valid  out  1  A_out/B_out/ctrl valid toward ALU
- out_ready  in  1  ALU side accepts the held instruction
- A_out  out  XLEN  rs1 value
- B_out  out  XLEN  imm or rs2 value per alu_src
- store_data_out  out  XLEN  rs2 value, regardless of alu_src
- ALUControl_out  out  4  registered alu_ctrl_in
- rd_addr_out  out  AW  registered rd_addr_in
- reg_write_out  out  1  registered reg_write_in; forced 0 when out_valid=0

Behaviour:
- Reset (synchronous): all NREG registers := 0; out_valid := 0; A_out, B_out, store_data_out, ALUControl_out, rd_addr_out, reg_write_out := 0. Reset has priority over every other event, including wb_en and flush.
- Register file write:
  - At the edge with wb_en=1 and wb_addr!=0: reg[wb_addr] := wb_data.
  - Writes to x0 are ignored; x0 always reads 0.
- Register file read: combinational from rs1_addr/rs2_addr. Address 0 returns 0.
- Same-cycle write/read collision: see Optional Feature.
- Operand select: B_next = alu_src ? imm : rs2_val. A_next = rs1_val. Width is XLEN throughout; there is no extension or truncation.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
  - Capture occurs when in_valid && in_ready && !flush. On capture, the output registers load A_next, B_next, rs2_val, alu_ctrl_in, rd_addr_in, reg_write_in, and out_valid := 1.
  - Drain: out_valid && out_ready with no capture leads to out_valid := 0.
  - Back-to-back: drain and capture in the same cycle leaves out_valid at 1 with the new contents. This gives full throughput of 1 instruction per clock.
  - Stall: out_valid=1 and out_ready=0 means all outputs hold and in_ready=0.
- Flush: at the edge, out_valid := 0 and reg_write_out := 0. Any same-cycle capture is dropped. Flush wins over capture and drain. Register file writes still occur during flush.
- Latency: one clock from accepted input to out_valid.
- Hazards:
  - This stage does no RAW detection against rd_addr_out. Upstream hazard logic must stall via in_valid.
  - The writeback path is the only data source newer than the array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through bypass. If wb_en=1, wb_addr!=0 and wb_addr equals rs1_addr (or rs2_addr), the read returns wb_data in the same cycle. An instruction captured in that cycle therefore sees the new value.
- Not defined: reads return the array contents before the edge. A same-cycle write is visible only from the following cycle.

Test Plan:
- Reset sequence: assert reset for 2 cycles while wb_en=1, wb_addr=5, wb_data=0xDEAD. Afterwards, read x5 with rs1_addr=5, alu_src=0, in_valid=1 → A_out=0x00000000 and out_valid=1 one cycle after capture.
- Write then read:
  - Write x3=0x12345678 and x4=0x00000010.
  - Next cycle issue rs1=3, rs2=4, alu_src=0, alu_ctrl_in=4'b0010 → A_out=0x12345678, B_out=0x00000010, store_data_out=0x00000010, ALUControl_out=4'b0010.
  - Repeat with alu_src=1 and imm=0xFFFFFFFC → B_out=0xFFFFFFFC, store_data_out=0x00000010.
- x0 protection: write x0=0xFFFFFFFF, then read rs1=0 and rs2=0 → A_out=0 and store_data_out=0.
- Same-cycle collision:
  - Hold x7=0x1 beforehand.
  - Write x7=0xAAAA5555 while capturing rs1=7.
  - With REGFILE_BYPASS_EN → A_out=0xAAAA5555. Without it → A_out=0x00000001.
- Backpressure:
  - Capture instruction I1, then hold out_ready=0 for 3 cycles with in_valid=1 presenting I2.
  - Expect in_ready=0, with outputs stable at I1 and out_valid=1.
  - Raise out_ready: I2 is captured that edge, and out_valid stays 1 with I2 contents.
- Flush:
  - With I1 held and out_ready=0, assert flush with in_valid=1 for I2 → next cycle out_valid=0, reg_write_out=0, and I2 is not captured.
  - A wb_en write to x9 in the same cycle still updates x9.
